iter_counter_bank: RTL and testbench

Parametrised bank of independent iteration counters for the accelerator's iterative datapaths. Each channel counts step events up to a per-run programmable limit, then either saturates and flags overflow or wraps and pulses overflow, selected by a mode input. It generalises the single fixed-limit (0x3FF) iteration counter to N channels, run-time limits, start/enable handshaking and a wrap mode. Outputs are registered through one alignment stage so that count and flags are coherent.

---
 rtl/iter_counter_pkg.sv | 16 +
 rtl/iter_counter_chan.sv | 77 +++++++
 rtl/iter_counter_bank.sv | 37 +++
 tb/tb_iter_counter_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/iter_counter_pkg.sv
// Shared types and constants for the iteration counter bank.
package iter_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 24;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_LIMIT = 24'h3FF;

endpackage

// File: rtl/iter_counter_chan.sv
// One iteration counter channel: control FSM, count/limit/mode registers
// and a single alignment stage so count, ovf and busy stay coherent.
module iter_counter_chan
  import iter_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             clr,
  input  logic             start,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_mode,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] lim;
  logic             mode;
  logic             ovf_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      lim   <= '0;
      mode  <= MODE_SAT;
      ovf_q <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // Alignment stage: publishes the internal state from the previous edge.
      count <= cnt;
      ovf   <= ovf_q;
      busy  <= (state == ST_RUN);

      if (clr) begin
        state <= ST_IDLE;
        cnt   <= '0;
        ovf_q <= 1'b0;
      end else if (start) begin
        state <= ST_RUN;
        cnt   <= '0;
        lim   <= limit;
        mode  <= wrap_mode;
        ovf_q <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            if (inc) begin
              if (cnt < lim) begin
                cnt   <= cnt + WIDTH'(1);
                ovf_q <= 1'b0;
              end else if (mode == MODE_WRAP) begin
                cnt   <= '0;
                ovf_q <= 1'b1;
              end else begin
                ovf_q <= 1'b1;
                state <= ST_SAT;
              end
            end else if (mode == MODE_WRAP) begin
              ovf_q <= 1'b0;
            end
          end
          ST_SAT:  state <= ST_SAT;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/iter_counter_bank.sv
// Bank of independent iteration counters sharing limit, mode and clear.
module iter_counter_bank
  import iter_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [WIDTH-1:0]          limit,
  input  logic                      wrap_mode,
  output logic [CHANNELS*WIDTH-1:0] counter,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       busy
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    iter_counter_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .clr       (clr),
      .start     (start[c]),
      .inc       (inc[c]),
      .limit     (limit),
      .wrap_mode (wrap_mode),
      .count     (counter[c*WIDTH +: WIDTH]),
      .ovf       (ovf[c]),
      .busy      (busy[c])
    );
  end

endmodule

// File: tb/tb_iter_counter_bank.sv
// Self-checking bench for iter_counter_bank: reference model + scoreboard queue,
// a priority vector table, and directed saturate/wrap/latched-limit sequences.
module tb_iter_counter_bank;
  import iter_counter_pkg::*;

  localparam int unsigned W  = DEFAULT_WIDTH;
  localparam int unsigned CH = 4;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            clr = 1'b0;
  logic [CH-1:0]   start = '0;
  logic [CH-1:0]   inc = '0;
  logic [W-1:0]    limit = '0;
  logic            wrap_mode = 1'b0;
  logic [CH*W-1:0] counter;
  logic [CH-1:0]   ovf;
  logic [CH-1:0]   busy;

  iter_counter_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clr       (clr),
    .start     (start),
    .inc       (inc),
    .limit     (limit),
    .wrap_mode (wrap_mode),
    .counter   (counter),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [CH*W-1:0] counter;
    logic [CH-1:0]   ovf;
    logic [CH-1:0]   busy;
  } exp_t;

  typedef struct {
    logic          clr;
    logic [CH-1:0] start;
    logic [CH-1:0] inc;
    logic [W-1:0]  limit;
    logic          wrap;
    logic [W-1:0]  e_cnt;
    logic          e_ovf;
    logic          e_busy;
  } vec_t;

  // Reference model of each channel's internal state.
  state_t     m_st   [CH];
  logic [W-1:0] m_cnt[CH];
  logic [W-1:0] m_lim[CH];
  logic       m_mode [CH];
  logic       m_ovf  [CH];
  exp_t       exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      e.counter[c*W +: W] = m_cnt[c];
      e.ovf[c]            = m_ovf[c];
      e.busy[c]           = (m_st[c] == ST_RUN);
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_st[c] = ST_IDLE; m_cnt[c] = '0; m_lim[c] = '0; m_mode[c] = 1'b0; m_ovf[c] = 1'b0;
    end
    exp_q.delete();
    exp_q.push_back(model_out());
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      if (clr) begin
        m_st[c] = ST_IDLE; m_cnt[c] = '0; m_ovf[c] = 1'b0;
      end else if (start[c]) begin
        m_st[c] = ST_RUN; m_cnt[c] = '0; m_lim[c] = limit; m_mode[c] = wrap_mode; m_ovf[c] = 1'b0;
      end else if (m_st[c] == ST_RUN) begin
        if (inc[c]) begin
          if (m_cnt[c] < m_lim[c]) begin
            m_cnt[c] = m_cnt[c] + 1'b1; m_ovf[c] = 1'b0;
          end else if (m_mode[c]) begin
            m_cnt[c] = '0; m_ovf[c] = 1'b1;
          end else begin
            m_ovf[c] = 1'b1; m_st[c] = ST_SAT;
          end
        end else if (m_mode[c]) begin
          m_ovf[c] = 1'b0;
        end
      end
    end
  endtask

  // Called #1 after a rising edge: drive, predict, clock, then check the
  // prediction made one step earlier (output lags inputs by two edges).
  task automatic drive(input logic c, input logic [CH-1:0] s, input logic [CH-1:0] i,
                       input logic [W-1:0] l, input logic w);
    exp_t e;
    clr = c; start = s; inc = i; limit = l; wrap_mode = w;
    model_step();
    exp_q.push_back(model_out());
    @(posedge aclk); #1;
    if (exp_q.size() < 2) begin
      chk("sb_underflow", 128'(exp_q.size()), 128'd2);
    end else begin
      e = exp_q.pop_front();
      chk("sb_counter", 128'(counter), 128'(e.counter));
      chk("sb_ovf",     128'(ovf),     128'(e.ovf));
      chk("sb_busy",    128'(busy),    128'(e.busy));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, limit, wrap_mode);
  endtask

  initial begin
    vec_t tab[$];
    int   first_ovf;
    int   first_nb;

    // Reset and inc without start
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_counter", 128'(counter), 128'd0);
    chk("reset_flags",   128'({ovf, busy}), 128'd0);
    aresetn = 1'b1;
    for (int k = 0; k < 4; k++) drive(1'b0, '0, 4'hF, DEFAULT_LIMIT, 1'b0);
    chk("nostart_counter", 128'(counter), 128'd0);
    chk("nostart_busy",    128'(busy),    128'd0);

    // Saturate at 0x3FF on channel 0
    first_ovf = -1; first_nb = -1;
    drive(1'b0, 4'b0001, '0, DEFAULT_LIMIT, MODE_SAT);
    for (int i = 1; i <= 1100; i++) begin
      drive(1'b0, '0, 4'b0001, DEFAULT_LIMIT, MODE_SAT);
      if (ovf[0] && first_ovf < 0) first_ovf = i;
      if (!busy[0] && first_nb < 0) first_nb = i;
    end
    chk("sat_ovf_edge",  128'(first_ovf), 128'd1025);
    chk("sat_busy_edge", 128'(first_nb),  128'd1025);
    chk("sat_hold_cnt",  128'(counter[0 +: W]), 128'h3FF);
    chk("sat_sticky",    128'(ovf[0]), 128'd1);

    // Wrap at 5 on channel 1
    drive(1'b0, 4'b0010, '0, 24'd5, MODE_WRAP);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, '0, 4'b0010, 24'd5, MODE_WRAP);
      chk("wrap_cnt", 128'(counter[W +: W]), 128'((i - 1) % 6));
      chk("wrap_ovf", 128'(ovf[1]), 128'((i > 1) && ((i - 1) % 6 == 0)));
    end
    idle(2);

    // Priority table for channel 2; expected values are for the row's own inputs
    tab.push_back('{0, 4'b0100, 4'b0100, 24'd3, 0, 24'd0, 0, 1});
    tab.push_back('{0, 4'b0000, 4'b0100, 24'd3, 0, 24'd1, 0, 1});
    tab.push_back('{0, 4'b0000, 4'b0100, 24'd3, 0, 24'd2, 0, 1});
    tab.push_back('{0, 4'b0100, 4'b0100, 24'd3, 0, 24'd0, 0, 1});
    tab.push_back('{0, 4'b0000, 4'b0100, 24'd3, 0, 24'd1, 0, 1});
    tab.push_back('{0, 4'b0000, 4'b0100, 24'd3, 0, 24'd2, 0, 1});
    tab.push_back('{0, 4'b0000, 4'b0100, 24'd3, 0, 24'd3, 0, 1});
    tab.push_back('{0, 4'b0000, 4'b0100, 24'd3, 0, 24'd3, 1, 0});
    tab.push_back('{0, 4'b0000, 4'b0100, 24'd3, 0, 24'd3, 1, 0});
    tab.push_back('{1, 4'b0100, 4'b0100, 24'd3, 0, 24'd0, 0, 0});
    tab.push_back('{0, 4'b0000, 4'b0100, 24'd3, 0, 24'd0, 0, 0});
    tab.push_back('{0, 4'b0100, 4'b0000, 24'd0, 1, 24'd0, 0, 1});
    tab.push_back('{0, 4'b0000, 4'b0100, 24'd0, 1, 24'd0, 1, 1});
    tab.push_back('{0, 4'b0000, 4'b0000, 24'd0, 1, 24'd0, 0, 1});
    tab.push_back('{0, 4'b0000, 4'b0000, 24'd0, 1, 24'd0, 0, 1});
    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].clr, tab[i].start, tab[i].inc, tab[i].limit, tab[i].wrap);
      if (i > 0) begin
        chk($sformatf("tab%0d_cnt", i - 1),  128'(counter[2*W +: W]), 128'(tab[i-1].e_cnt));
        chk($sformatf("tab%0d_ovf", i - 1),  128'(ovf[2]),  128'(tab[i-1].e_ovf));
        chk($sformatf("tab%0d_busy", i - 1), 128'(busy[2]), 128'(tab[i-1].e_busy));
      end
    end

    // Latched limit on channel 3, zero limit on channel 0
    drive(1'b0, 4'b0001, '0, 24'd0, MODE_SAT);
    drive(1'b0, 4'b1000, '0, 24'd10, MODE_SAT);
    for (int i = 0; i < 14; i++) drive(1'b0, '0, 4'b1001, 24'd2, MODE_WRAP);
    idle(2);
    chk("latch_cnt3", 128'(counter[3*W +: W]), 128'd10);
    chk("latch_ovf3", 128'(ovf[3]), 128'd1);
    chk("zero_cnt0",  128'(counter[0 +: W]), 128'd0);
    chk("zero_ovf0",  128'(ovf[0]), 128'd1);

    // Independent channels with random traffic
    drive(1'b0, 4'b0001, '0, 24'd7,  MODE_SAT);
    drive(1'b0, 4'b0010, '0, 24'd13, MODE_WRAP);
    drive(1'b0, 4'b0100, '0, 24'd4,  MODE_WRAP);
    drive(1'b0, 4'b1000, '0, 24'd20, MODE_SAT);
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 199) == 0),
            ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'b0000,
            4'($urandom), 24'($urandom_range(0, 15)), 1'($urandom));
    end

    // Asynchronous reset mid-cycle, mid-run
    drive(1'b0, 4'b1111, '0, 24'd9, MODE_WRAP);
    drive(1'b0, '0, 4'b1111, 24'd9, MODE_WRAP);
    drive(1'b0, '0, 4'b1111, 24'd9, MODE_WRAP);
    clr = 1'b0; start = '0; inc = '0;
    #3 aresetn = 1'b0;
    #1;
    chk("async_rst_counter", 128'(counter), 128'd0);
    chk("async_rst_flags",   128'({ovf, busy}), 128'd0);
    model_reset();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 4'hF, 24'd9, MODE_SAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
